mem_io_responder: RTL and testbench

//  Bus-side responder for the core's byte memory port (mem_a/mem_dout/mem_wr in, mem_din/io_buffer_full out).

---
 rtl/mem_io_responder.sv | 144 ++++++++++++++
 tb/tb_mem_io_responder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// Byte memory port responder: 128KB RAM, UART TX queue, RX source,
// free-running cycle counter and program-stop flag at a[17:16]==2'b11.
module mem_io_responder #(
    parameter int RAM_AW      = 17,
    parameter int TXQ_AW      = 4,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_pop,
    output logic        prog_stop,
    output logic        tx_overflow
);

    localparam int DEPTH = 1 << TXQ_AW;
    localparam int CW    = TXQ_AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH - FULL_MARGIN);

    logic [7:0]        r_ram [0:(1<<RAM_AW)-1];
    logic [7:0]        r_txq [0:DEPTH-1];
    logic [TXQ_AW-1:0] r_wr_ptr;
    logic [TXQ_AW-1:0] r_rd_ptr;
    logic [CW-1:0]     r_tx_cnt;
    logic [31:0]       r_cnt;
    logic [31:0]       r_snap;

    logic              w_io;
    logic [RAM_AW-1:0] w_idx;
    logic [2:0]        w_sel;
    logic              w_rd;
    logic              w_wr;
    logic              w_ram_wr;
    logic              w_tx_pop;
    logic              w_push_req;
    logic              w_push;
    logic [7:0]        w_push_data;
    logic [CW-1:0]     w_cnt_next;
    logic [7:0]        w_io_rd_data;
    logic              w_unused;

    assign w_io     = (mem_a[17:16] == 2'b11);
    assign w_idx    = mem_a[RAM_AW-1:0];
    assign w_sel    = mem_a[2:0];
    assign w_rd     = rdy_in & ~mem_wr;
    assign w_wr     = rdy_in & mem_wr;
    assign w_ram_wr = w_wr & ~w_io;
    assign w_unused = ^mem_a[31:18];

    assign tx_valid = (r_tx_cnt != '0);
    assign tx_data  = tx_valid ? r_txq[r_rd_ptr] : 8'h00;
    assign w_tx_pop = tx_valid & tx_ready;

    // 0x30004 writes push a 0x00 terminator past the zero filter
    assign w_push_req = w_wr & w_io &
                        (((w_sel == 3'd0) & (mem_dout != 8'h00)) |
                         (w_sel == 3'd4));
    assign w_push_data = (w_sel == 3'd4) ? 8'h00 : mem_dout;
    assign w_push      = w_push_req & ((r_tx_cnt != DEPTH_C) | w_tx_pop);

    always_comb begin
        w_cnt_next = r_tx_cnt;
        if (w_push & ~w_tx_pop) begin
            w_cnt_next = r_tx_cnt + CW'(1);
        end else if (~w_push & w_tx_pop) begin
            w_cnt_next = r_tx_cnt - CW'(1);
        end
    end

    always_comb begin
        w_io_rd_data = 8'h00;
        unique case (w_sel)
            3'd0:    w_io_rd_data = rx_valid ? rx_data : 8'h00;
            3'd4:    w_io_rd_data = r_cnt[7:0];
            3'd5:    w_io_rd_data = r_snap[15:8];
            3'd6:    w_io_rd_data = r_snap[23:16];
            3'd7:    w_io_rd_data = r_snap[31:24];
            default: w_io_rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (w_ram_wr) begin
            r_ram[w_idx] <= mem_dout;
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_txq[r_wr_ptr] <= w_push_data;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mem_din        <= 8'h00;
            io_buffer_full <= 1'b0;
            rx_pop         <= 1'b0;
            prog_stop      <= 1'b0;
            tx_overflow    <= 1'b0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_tx_cnt       <= '0;
            r_cnt          <= 32'd0;
            r_snap         <= 32'd0;
        end else begin
            r_cnt  <= r_cnt + 32'd1;
            rx_pop <= w_rd & w_io & (w_sel == 3'd0) & rx_valid;
            if (w_rd) begin
                mem_din <= w_io ? w_io_rd_data : r_ram[w_idx];
            end
            // latch the whole counter so bytes 1..3 match byte 0
            if (w_rd & w_io & (w_sel == 3'd4)) begin
                r_snap <= r_cnt;
            end
            if (w_wr & w_io & (w_sel == 3'd4)) begin
                prog_stop <= 1'b1;
            end
            if (w_push_req & ~w_push) begin
                tx_overflow <= 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + TXQ_AW'(1);
            end
            if (w_tx_pop) begin
                r_rd_ptr <= r_rd_ptr + TXQ_AW'(1);
            end
            r_tx_cnt       <= w_cnt_next;
            io_buffer_full <= (w_cnt_next >= FULL_LVL);
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: driver queues expectations,
// a negedge monitor compares them against a queue/array reference model.
module tb_mem_io_responder;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b0;
    logic [31:0] mem_a = 32'd0;
    logic [7:0]  mem_dout = 8'd0;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_pop;
    logic        prog_stop;
    logic        tx_overflow;

    mem_io_responder dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in),
        .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
        .mem_din(mem_din), .io_buffer_full(io_buffer_full),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
        .prog_stop(prog_stop), .tx_overflow(tx_overflow)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [7:0] din; logic pop; } rd_t;
    typedef struct { int cyc; logic [7:0] data; logic stop; } wr_t;

    int          tb_cyc = 0;
    int          rst_cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    rd_t         rdq [$];
    wr_t         wrq [$];
    logic [7:0]  txm [$];
    logic [7:0]  ram_m [int];
    int          wl [$];
    logic [31:0] snap_m = 32'd0;
    logic [7:0]  last_din = 8'd0;
    logic        ovf_m = 1'b0;
    logic        stop_m = 1'b0;
    logic        nxt_rxv = 1'b0;
    logic [7:0]  nxt_rxd = 8'd0;
    logic        nxt_txr = 1'b0;

    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s actual=%h required=%h cyc=%0d", nm, act, exp, tb_cyc);
        else
            n_pass++;
    endfunction

    // One bus cycle; model effects are recorded only when rdy is high
    task automatic bus(input logic rdy, input logic [31:0] a,
                       input logic wr, input logic [7:0] d);
        rd_t         r;
        wr_t         w;
        logic [31:0] c;
        logic [2:0]  sel;
        logic        io;
        @(posedge clk);
        #1;
        rdy_in = rdy; mem_a = a; mem_wr = wr; mem_dout = d;
        rx_valid = nxt_rxv; rx_data = nxt_rxd; tx_ready = nxt_txr;
        if (!rdy) return;
        io  = (a[17:16] == 2'b11);
        sel = a[2:0];
        if (wr) begin
            if (!io) begin
                ram_m[int'(a[16:0])] = d;
                wl.push_back(int'(a[16:0]));
            end else if ((sel == 3'd0 && d != 8'd0) || sel == 3'd4) begin
                w.cyc  = tb_cyc + 1;
                w.data = (sel == 3'd4) ? 8'h00 : d;
                w.stop = (sel == 3'd4);
                wrq.push_back(w);
            end
        end else begin
            r.cyc = tb_cyc + 1; r.din = 8'h00; r.pop = 1'b0;
            if (!io) begin
                r.din = ram_m[int'(a[16:0])];
            end else begin
                case (sel)
                    3'd0: begin
                        r.din = nxt_rxv ? nxt_rxd : 8'h00;
                        r.pop = nxt_rxv;
                    end
                    3'd4: begin
                        c = 32'(tb_cyc - rst_cyc);
                        snap_m = c;
                        r.din = c[7:0];
                    end
                    3'd5: r.din = snap_m[15:8];
                    3'd6: r.din = snap_m[23:16];
                    3'd7: r.din = snap_m[31:24];
                    default: r.din = 8'h00;
                endcase
            end
            rdq.push_back(r);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            bus(1'b0, $urandom, 1'($urandom), 8'($urandom));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_in = 1'b1; rdy_in = 1'b0;
        #1;
        chk("rst_mem_din", {24'd0, mem_din}, 32'd0);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_full", {31'd0, io_buffer_full}, 32'd0);
        chk("rst_stop", {31'd0, prog_stop}, 32'd0);
        chk("rst_ovf", {31'd0, tx_overflow}, 32'd0);
        chk("rst_rx_pop", {31'd0, rx_pop}, 32'd0);
        txm.delete(); rdq.delete(); wrq.delete();
        last_din = 8'd0; ovf_m = 1'b0; stop_m = 1'b0; snap_m = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_in = 1'b0;
        rst_cyc = tb_cyc;
    endtask

    // State after posedge tb_cyc is checked, then the next edge is modelled
    always @(negedge clk) begin
        logic [7:0] exp_din;
        logic       exp_pop;
        wr_t        w;
        if (tb_cyc >= 1) begin
            exp_din = last_din;
            exp_pop = 1'b0;
            if (rdq.size() != 0 && rdq[0].cyc == tb_cyc) begin
                exp_din = rdq[0].din;
                exp_pop = rdq[0].pop;
                void'(rdq.pop_front());
            end
            last_din = exp_din;
            chk("mem_din", {24'd0, mem_din}, {24'd0, exp_din});
            chk("rx_pop", {31'd0, rx_pop}, {31'd0, exp_pop});
            chk("tx_valid", {31'd0, tx_valid}, {31'd0, txm.size() != 0});
            chk("io_buffer_full", {31'd0, io_buffer_full}, {31'd0, txm.size() >= 14});
            chk("tx_overflow", {31'd0, tx_overflow}, {31'd0, ovf_m});
            chk("prog_stop", {31'd0, prog_stop}, {31'd0, stop_m});
            if (!rst_in) begin
                if (txm.size() != 0 && tx_ready) begin
                    chk("tx_data", {24'd0, tx_data}, {24'd0, txm[0]});
                    void'(txm.pop_front());
                end
                while (wrq.size() != 0 && wrq[0].cyc == tb_cyc + 1) begin
                    w = wrq.pop_front();
                    if (txm.size() < 16) txm.push_back(w.data);
                    else ovf_m = 1'b1;
                    if (w.stop) stop_m = 1'b1;
                end
            end
        end
    end

    initial begin
        int          op;
        int          idx;
        logic [31:0] a;
        logic [2:0]  s;
        repeat (3) @(posedge clk);
        #1;
        rst_in = 1'b0;
        rst_cyc = tb_cyc;

        bus(1'b1, 32'h0000_0123, 1'b1, 8'hA5);
        bus(1'b1, 32'h0000_0123, 1'b0, 8'h00);
        idle(2);

        nxt_txr = 1'b1;
        bus(1'b1, 32'h0003_0000, 1'b1, 8'h48);
        bus(1'b1, 32'h0003_0000, 1'b1, 8'h69);
        bus(1'b1, 32'h0003_0000, 1'b1, 8'h00);
        idle(4);

        nxt_txr = 1'b0;
        for (int i = 0; i < 17; i++)
            bus(1'b1, 32'h0003_0000, 1'b1, 8'(8'h41 + i));
        idle(3);
        nxt_txr = 1'b1;
        idle(20);

        idle(1000);
        bus(1'b1, 32'h0003_0004, 1'b0, 8'h00);
        bus(1'b1, 32'h0003_0005, 1'b0, 8'h00);
        idle(3);
        bus(1'b1, 32'h0003_0006, 1'b0, 8'h00);
        bus(1'b1, 32'h0003_0007, 1'b0, 8'h00);

        nxt_rxv = 1'b1; nxt_rxd = 8'h37;
        bus(1'b1, 32'h0003_0000, 1'b0, 8'h00);
        nxt_rxv = 1'b0;
        bus(1'b1, 32'h0003_0000, 1'b0, 8'h00);
        nxt_rxv = 1'b1;
        bus(1'b0, 32'h0003_0000, 1'b0, 8'h00);
        nxt_rxv = 1'b0;
        idle(2);

        for (int i = 0; i < 800; i++) begin
            op = $urandom_range(0, 9);
            nxt_txr = 1'($urandom);
            nxt_rxv = 1'($urandom);
            nxt_rxd = 8'($urandom);
            case (op)
                0, 1, 2: begin
                    a = {14'($urandom), 2'($urandom_range(0, 2)),
                         16'($urandom_range(0, 63) + 256)};
                    bus($urandom_range(0, 4) != 0, a, 1'b1, 8'($urandom));
                end
                3, 4: begin
                    if (wl.size() == 0) begin
                        idle(1);
                    end else begin
                        idx = wl[$urandom_range(0, wl.size() - 1)];
                        a = {14'($urandom), 1'b0, 17'(idx)};
                        bus($urandom_range(0, 4) != 0, a, 1'b0, 8'($urandom));
                    end
                end
                5, 9: bus($urandom_range(0, 4) != 0,
                          {14'($urandom), 2'b11, 13'($urandom), 3'd0},
                          1'b0, 8'($urandom));
                6: bus($urandom_range(0, 4) != 0,
                       {14'($urandom), 2'b11, 13'($urandom), 3'd0}, 1'b1,
                       ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
                7: begin
                    s = 3'(4 + $urandom_range(0, 3));
                    bus($urandom_range(0, 4) != 0,
                        {14'($urandom), 2'b11, 13'($urandom), s},
                        1'b0, 8'($urandom));
                end
                default: begin
                    s = 3'($urandom_range(1, 3));
                    if ($urandom_range(0, 1) == 1 && s == 3'd1) s = 3'd6;
                    bus($urandom_range(0, 4) != 0,
                        {14'($urandom), 2'b11, 13'($urandom), s},
                        1'($urandom), 8'($urandom));
                end
            endcase
        end
        nxt_txr = 1'b1; nxt_rxv = 1'b0;
        idle(20);

        nxt_txr = 1'b0;
        bus(1'b1, 32'h0003_0004, 1'b1, 8'h55);
        for (int i = 0; i < 5; i++)
            bus(1'b1, 32'h0003_0000, 1'b1, 8'(8'h61 + i));
        nxt_txr = 1'b1;
        idle(2);
        do_reset();
        nxt_txr = 1'b0;
        idle(4);
        bus(1'b1, 32'h0003_0004, 1'b0, 8'h00);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
